// File: rtl/shared_wr_merge.sv
// Write merge front end: arbitrates three 16-bit lane writers into a small coalescing FIFO
// that feeds a 32-bit byte-enabled memory write port. Define SHARED_WR_RR_EN for round-robin.
module shared_wr_merge #(
   parameter int unsigned AW    = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2:0]                 req_valid,
   input  logic [AW-1:0]              req_addr1,
   input  logic [AW-1:0]              req_addr2,
   input  logic [AW-1:0]              req_addr3,
   input  logic [15:0]                req_data1,
   input  logic [15:0]                req_data2,
   input  logic [15:0]                req_data3,
   output logic [2:0]                 req_ready,
   output logic                       mem_wr_en,
   output logic [AW-1:0]              mem_wr_addr,
   output logic [31:0]                mem_wr_data,
   output logic [3:0]                 mem_wr_be,
   input  logic                       mem_wr_ready,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [3:0]    be_q   [DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q, tail_ptr;
   logic [CW-1:0] count_q;

   logic [AW-1:0] r_addr [3];
   logic [31:0]   r_word [3];
   logic [3:0]    r_be   [3];
   logic [2:0]    mergeable, eligible, grant;
   logic [1:0]    gidx;
   logic          pop, push, merge, any_grant;
   logic [AW-1:0] sel_addr;
   logic [31:0]   sel_word, sel_mask;
   logic [3:0]    sel_be;
   logic          sel_merge;

   always_comb begin
      r_addr[0] = req_addr1;
      r_addr[1] = req_addr2;
      r_addr[2] = req_addr3;
      r_word[0] = {16'h0000, req_data1};
      r_word[1] = {8'h00, req_data2, 8'h00};
      r_word[2] = {req_data3, 16'h0000};
      r_be[0]   = 4'b0011;
      r_be[1]   = 4'b0110;
      r_be[2]   = 4'b1100;
   end

   assign pop      = (count_q != '0) & mem_wr_ready;
   assign tail_ptr = wr_ptr_q - PW'(1);

   // A lone head that is leaving this cycle cannot absorb a merge.
   always_comb begin
      mergeable = '0;
      eligible  = '0;
      for (int k = 0; k < 3; k++) begin
         mergeable[k] = (count_q != '0) && (addr_q[tail_ptr] == r_addr[k]) &&
                        !((count_q == CW'(1)) && pop);
         eligible[k]  = req_valid[k] &&
                        (mergeable[k] || (count_q < CW'(DEPTH)) || pop);
      end
   end

`ifdef SHARED_WR_RR_EN
   logic [1:0] ptr_q;
   int         j;
   logic       found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < 3; i++) begin
         j = (int'(ptr_q) + i) % 3;
         if (!found && eligible[j]) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 2'd0;
      end else if (any_grant) begin
         ptr_q <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
      end
   end
`else
   always_comb begin
      grant    = '0;
      grant[0] = eligible[0];
      grant[1] = eligible[1] & ~eligible[0];
      grant[2] = eligible[2] & ~eligible[1] & ~eligible[0];
   end
`endif

   always_comb begin
      gidx = 2'd0;
      if (grant[1]) gidx = 2'd1;
      if (grant[2]) gidx = 2'd2;
   end

   assign any_grant = (|grant) & ~rst;
   assign req_ready = rst ? 3'b000 : grant;

   always_comb begin
      sel_addr  = r_addr[gidx];
      sel_word  = r_word[gidx];
      sel_be    = r_be[gidx];
      sel_merge = mergeable[gidx];
      sel_mask  = {{8{sel_be[3]}}, {8{sel_be[2]}}, {8{sel_be[1]}}, {8{sel_be[0]}}};
   end

   assign push  = any_grant & ~sel_merge;
   assign merge = any_grant & sel_merge;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // When full with a pop, wr_ptr equals rd_ptr: the departing head slot is reused.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= sel_addr;
         data_q[wr_ptr_q] <= sel_word;
         be_q[wr_ptr_q]   <= sel_be;
      end else if (merge) begin
         data_q[tail_ptr] <= (data_q[tail_ptr] & ~sel_mask) | (sel_word & sel_mask);
         be_q[tail_ptr]   <= be_q[tail_ptr] | sel_be;
      end
   end

   always_comb begin
      mem_wr_en   = (count_q != '0);
      mem_wr_addr = '0;
      mem_wr_data = '0;
      mem_wr_be   = '0;
      if (mem_wr_en) begin
         mem_wr_addr = addr_q[rd_ptr_q];
         mem_wr_data = data_q[rd_ptr_q];
         mem_wr_be   = be_q[rd_ptr_q];
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_shared_wr_merge.sv
// Directed bench for shared_wr_merge; adds a round-robin scenario when SHARED_WR_RR_EN is set.
module tb_shared_wr_merge;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [3:0]  req_addr1, req_addr2, req_addr3;
   logic [15:0] req_data1, req_data2, req_data3;
   logic [2:0]  req_ready;
   logic        mem_wr_en;
   logic [3:0]  mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_wr_be;
   logic        mem_wr_ready;
   logic [2:0]  count;

   int n_cmp  = 0;
   int n_fail = 0;

   shared_wr_merge #(.AW(4), .DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_addr1    (req_addr1),
      .req_addr2    (req_addr2),
      .req_addr3    (req_addr3),
      .req_data1    (req_data1),
      .req_data2    (req_data2),
      .req_data3    (req_data3),
      .req_ready    (req_ready),
      .mem_wr_en    (mem_wr_en),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_be    (mem_wr_be),
      .mem_wr_ready (mem_wr_ready),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 3'b000;
      mem_wr_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 3'b111;
      req_addr1 = 4'd1; req_addr2 = 4'd2; req_addr3 = 4'd3;
      req_data1 = 16'h1; req_data2 = 16'h2; req_data3 = 16'h3;
      mem_wr_ready = 1'b0;
      #1;
      n_cmp++;
      if (req_ready !== 3'b000) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 000", req_ready);
      end
      tick();
      tick();
      n_cmp++;
      if (count !== 3'd0 || mem_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: got count %0d en %b expected 0 0", count, mem_wr_en);
      end
      n_cmp++;
      if (mem_wr_addr !== 4'd0 || mem_wr_data !== 32'd0 || mem_wr_be !== 4'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %h %h %b expected zeros",
                            mem_wr_addr, mem_wr_data, mem_wr_be);
      end
      rst = 1'b0;
      req_valid = 3'b000;
      #1;
   endtask

   task automatic test_single();
      do_reset();
      mem_wr_ready = 1'b1;
      req_valid = 3'b001; req_addr1 = 4'd3; req_data1 = 16'hBEEF;
      #1;
      n_cmp++;
      if (req_ready !== 3'b001) begin
         n_fail++; $display("FAIL single_ready: got %b expected 001", req_ready);
      end
      tick();
      req_valid = 3'b000;
      #1;
      n_cmp++;
      if (mem_wr_en !== 1'b1 || mem_wr_addr !== 4'd3 || mem_wr_data !== 32'h0000BEEF ||
          mem_wr_be !== 4'b0011) begin
         n_fail++; $display("FAIL single_out: got en %b addr %h data %h be %b expected 1 3 0000beef 0011",
                            mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be);
      end
      tick();
      n_cmp++;
      if (mem_wr_en !== 1'b0 || count !== 3'd0) begin
         n_fail++; $display("FAIL single_drain: got en %b count %0d expected 0 0", mem_wr_en, count);
      end
   endtask

   task automatic test_priority();
      logic [2:0]  exp_rdy [3];
      logic [3:0]  exp_addr [3];
      logic [31:0] exp_data [3];
      logic [3:0]  exp_be [3];
      exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100;
      exp_addr[0] = 4'd1; exp_addr[1] = 4'd2; exp_addr[2] = 4'd3;
      exp_data[0] = 32'h0000A001; exp_data[1] = 32'h00B00200; exp_data[2] = 32'hC0030000;
      exp_be[0] = 4'b0011; exp_be[1] = 4'b0110; exp_be[2] = 4'b1100;
      do_reset();
      req_addr1 = 4'd1; req_addr2 = 4'd2; req_addr3 = 4'd3;
      req_data1 = 16'hA001; req_data2 = 16'hB002; req_data3 = 16'hC003;
      req_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (req_ready !== exp_rdy[i]) begin
            n_fail++; $display("FAIL prio_grant%0d: got %b expected %b", i, req_ready, exp_rdy[i]);
         end
         tick();
         req_valid = req_valid & ~exp_rdy[i];
      end
      #1;
      n_cmp++;
      if (count !== 3'd3) begin
         n_fail++; $display("FAIL prio_count: got %0d expected 3", count);
      end
      mem_wr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (mem_wr_en !== 1'b1 || mem_wr_addr !== exp_addr[i] || mem_wr_data !== exp_data[i] ||
             mem_wr_be !== exp_be[i]) begin
            n_fail++; $display("FAIL prio_drain%0d: got %b %h %h %b expected 1 %h %h %b", i, mem_wr_en,
                               mem_wr_addr, mem_wr_data, mem_wr_be, exp_addr[i], exp_data[i], exp_be[i]);
         end
         tick();
      end
      n_cmp++;
      if (count !== 3'd0) begin
         n_fail++; $display("FAIL prio_empty: got %0d expected 0", count);
      end
   endtask

   task automatic test_merge();
      do_reset();
      req_valid = 3'b001; req_addr1 = 4'd5; req_data1 = 16'h1111;
      tick();
      req_valid = 3'b100; req_addr3 = 4'd5; req_data3 = 16'h2222;
      #1;
      n_cmp++;
      if (req_ready !== 3'b100) begin
         n_fail++; $display("FAIL merge_ready: got %b expected 100", req_ready);
      end
      tick();
      req_valid = 3'b000;
      #1;
      n_cmp++;
      if (count !== 3'd1 || mem_wr_be !== 4'b1111 || mem_wr_data !== 32'h22221111) begin
         n_fail++; $display("FAIL merge_13: got count %0d be %b data %h expected 1 1111 22221111",
                            count, mem_wr_be, mem_wr_data);
      end
      req_valid = 3'b010; req_addr2 = 4'd5; req_data2 = 16'hABCD;
      tick();
      req_valid = 3'b000;
      #1;
      n_cmp++;
      if (count !== 3'd1 || mem_wr_be !== 4'b1111 || mem_wr_data !== 32'h22ABCD11 ||
          mem_wr_addr !== 4'd5) begin
         n_fail++; $display("FAIL merge_2: got count %0d be %b data %h addr %h expected 1 1111 22abcd11 5",
                            count, mem_wr_be, mem_wr_data, mem_wr_addr);
      end
   endtask

   task automatic test_no_merge_on_pop();
      do_reset();
      mem_wr_ready = 1'b1;
      req_valid = 3'b001; req_addr1 = 4'd6; req_data1 = 16'h1234;
      tick();
      req_data1 = 16'h5678;
      #1;
      n_cmp++;
      if (req_ready !== 3'b001) begin
         n_fail++; $display("FAIL popmerge_ready: got %b expected 001", req_ready);
      end
      tick();
      req_valid = 3'b000;
      #1;
      n_cmp++;
      if (count !== 3'd1 || mem_wr_data !== 32'h00005678 || mem_wr_be !== 4'b0011) begin
         n_fail++; $display("FAIL popmerge_push: got count %0d data %h be %b expected 1 00005678 0011",
                            count, mem_wr_data, mem_wr_be);
      end
      tick();
   endtask

   task automatic test_full();
      logic [3:0]  exp_addr [4];
      logic [31:0] exp_data [4];
      logic [3:0]  exp_be [4];
      exp_addr[0] = 4'd9;  exp_data[0] = 32'h00001001; exp_be[0] = 4'b0011;
      exp_addr[1] = 4'd10; exp_data[1] = 32'h00001002; exp_be[1] = 4'b0011;
      exp_addr[2] = 4'd11; exp_data[2] = 32'h00334403; exp_be[2] = 4'b0111;
      exp_addr[3] = 4'd13; exp_data[3] = 32'h55660000; exp_be[3] = 4'b1100;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_valid = 3'b001; req_addr1 = 4'(8 + i); req_data1 = 16'(16'h1000 + i);
         tick();
      end
      req_valid = 3'b010; req_addr2 = 4'd12; req_data2 = 16'h3344;
      #1;
      n_cmp++;
      if (count !== 3'd4 || req_ready !== 3'b000) begin
         n_fail++; $display("FAIL full_block: got count %0d ready %b expected 4 000", count, req_ready);
      end
      tick();
      n_cmp++;
      if (count !== 3'd4 || mem_wr_addr !== 4'd8) begin
         n_fail++; $display("FAIL full_hold: got count %0d head %h expected 4 8", count, mem_wr_addr);
      end
      req_addr2 = 4'd11;
      #1;
      n_cmp++;
      if (req_ready !== 3'b010) begin
         n_fail++; $display("FAIL full_merge_ready: got %b expected 010", req_ready);
      end
      tick();
      req_valid = 3'b100; req_addr3 = 4'd13; req_data3 = 16'h5566;
      mem_wr_ready = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== 3'b100) begin
         n_fail++; $display("FAIL full_pushpop_ready: got %b expected 100", req_ready);
      end
      tick();
      req_valid = 3'b000;
      #1;
      n_cmp++;
      if (count !== 3'd4 || mem_wr_addr !== 4'd9) begin
         n_fail++; $display("FAIL full_pushpop: got count %0d head %h expected 4 9", count, mem_wr_addr);
      end
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (mem_wr_en !== 1'b1 || mem_wr_addr !== exp_addr[i] || mem_wr_data !== exp_data[i] ||
             mem_wr_be !== exp_be[i]) begin
            n_fail++; $display("FAIL full_drain%0d: got %b %h %h %b expected 1 %h %h %b", i, mem_wr_en,
                               mem_wr_addr, mem_wr_data, mem_wr_be, exp_addr[i], exp_data[i], exp_be[i]);
         end
         tick();
      end
      n_cmp++;
      if (count !== 3'd0) begin
         n_fail++; $display("FAIL full_empty: got %0d expected 0", count);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         req_valid = 3'b001; req_addr1 = 4'(i); req_data1 = 16'(i);
         tick();
      end
      n_cmp++;
      if (count !== 3'd3) begin
         n_fail++; $display("FAIL mid_fill: got %0d expected 3", count);
      end
      rst = 1'b1; req_addr1 = 4'd4;
      tick();
      rst = 1'b0; req_valid = 3'b000;
      #1;
      n_cmp++;
      if (count !== 3'd0 || mem_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: got count %0d en %b expected 0 0", count, mem_wr_en);
      end
      req_valid = 3'b010; req_addr2 = 4'd0; req_data2 = 16'h00FF;
      tick();
      req_valid = 3'b000;
      #1;
      n_cmp++;
      if (mem_wr_en !== 1'b1 || mem_wr_addr !== 4'd0 || mem_wr_be !== 4'b0110 ||
          mem_wr_data !== 32'h0000FF00) begin
         n_fail++; $display("FAIL mid_after: got %b %h %b %h expected 1 0 0110 0000ff00",
                            mem_wr_en, mem_wr_addr, mem_wr_be, mem_wr_data);
      end
   endtask

   task automatic test_arbitration();
      logic [2:0] exp_a [6];
      logic [2:0] exp_b [4];
`ifdef SHARED_WR_RR_EN
      exp_a[0] = 3'b001; exp_a[1] = 3'b010; exp_a[2] = 3'b100;
      exp_a[3] = 3'b001; exp_a[4] = 3'b010; exp_a[5] = 3'b100;
      exp_b[0] = 3'b001; exp_b[1] = 3'b100; exp_b[2] = 3'b001; exp_b[3] = 3'b100;
`else
      for (int i = 0; i < 6; i++) exp_a[i] = 3'b001;
      exp_b[0] = 3'b001; exp_b[1] = 3'b001; exp_b[2] = 3'b001; exp_b[3] = 3'b001;
`endif
      do_reset();
      mem_wr_ready = 1'b1;
      req_addr1 = 4'd1; req_addr2 = 4'd2; req_addr3 = 4'd3;
      req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_cmp++;
         if (req_ready !== exp_a[i]) begin
            n_fail++; $display("FAIL arb_all%0d: got %b expected %b", i, req_ready, exp_a[i]);
         end
         tick();
      end
      req_valid = 3'b101;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (req_ready !== exp_b[i]) begin
            n_fail++; $display("FAIL arb_13_%0d: got %b expected %b", i, req_ready, exp_b[i]);
         end
         tick();
      end
      req_valid = 3'b000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_merge();
      test_no_merge_on_pop();
      test_full();
      test_reset_mid();
      test_arbitration();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
